program_memory: RTL and testbench

Parametrised instruction store for the PUC CPU core, replacing the fixed-size combinational instruction ROM. It has a registered fetch port and a byte-stream load port, so a host such as a UART bridge can rewrite the program at run time without re-synthesis. It sits between the PC register and the decoder; the decoder must treat `instruction_valid` as its fetch-ready qualifier.

---
 rtl/program_memory.sv | 74 +++++++
 tb/tb_program_memory.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// program_memory: reloadable instruction store with registered fetch and byte-stream load port
module program_memory #(
  parameter int    PC_WIDTH          = 8,
  parameter int    INSTRUCTION_WIDTH = 16,
  parameter int    DEPTH             = 256,
  parameter string INIT_FILE         = "asm.hex"
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic                         fetch_req,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         instruction_valid,
  input  logic                         load_start,
  input  logic [7:0]                   load_byte,
  input  logic                         load_valid,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         loading,
  output logic [PC_WIDTH:0]            load_count,
  output logic                         load_error
);
  localparam int BW = (INSTRUCTION_WIDTH + 7) / 8;
  localparam int CW = BW > 1 ? $clog2(BW) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PC_WIDTH:0] DEPTH_W = (PC_WIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_B = CW'(BW - 1);
  typedef enum logic {RUN, LOAD} state_t;
  state_t state;
  logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] asm_q, word;
  logic [CW-1:0] cnt;
  logic take, word_done, room, we, accept;
  assign loading    = state == LOAD;
  assign load_ready = loading;
  assign accept     = fetch_req && !load_start;
  assign take       = loading && load_valid;
  assign word_done  = take && (load_last || cnt == LAST_B);
  assign room       = load_count < DEPTH_W;
  assign we         = word_done && room;
  assign word = asm_q | INSTRUCTION_WIDTH'((BW * 8)'(load_byte) << {LAST_B - cnt, 3'b000});
  always_ff @(posedge clock)
    if (we) mem[load_count[AW-1:0]] <= word;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= RUN;
      instruction       <= '0;
      instruction_valid <= 1'b0;
      load_count        <= '0;
      load_error        <= 1'b0;
      cnt               <= '0;
      asm_q             <= '0;
    end else if (state == RUN) begin
      instruction_valid <= accept;
      if (accept) instruction <= ({1'b0, pc} < DEPTH_W) ? mem[pc[AW-1:0]] : '0;
      if (load_start) begin
        state      <= LOAD;
        load_count <= '0;
        load_error <= 1'b0;
        cnt        <= '0;
        asm_q      <= '0;
      end
    end else begin
      instruction_valid <= 1'b0;
      if (take) begin
        cnt   <= word_done ? '0 : cnt + 1'b1;
        asm_q <= word_done ? '0 : word;
        if (!room) load_error <= 1'b1;
        if (we) load_count <= load_count + 1'b1;
        if (load_last) state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed checks of load, fetch, overrun, priority and async reset
// on a 16-bit/DEPTH=4 instance (a) and a 24-bit/DEPTH=200 instance (b) sharing stimulus.
module tb_program_memory;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [7:0] pc = '0, load_byte = '0;
  logic fetch_req = 1'b0, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [15:0] a_instruction;
  logic [23:0] b_instruction;
  logic a_instruction_valid, b_instruction_valid, a_load_ready, b_load_ready;
  logic a_loading, b_loading, a_load_error, b_load_error;
  logic [8:0] a_load_count, b_load_count;
  int errors = 0, checks = 0;

  always #5 clock = ~clock;

  program_memory #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16), .DEPTH(4), .INIT_FILE("")) u_a (
    .clock(clock), .reset_n(reset_n), .pc(pc), .fetch_req(fetch_req),
    .instruction(a_instruction), .instruction_valid(a_instruction_valid),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(a_load_ready), .loading(a_loading), .load_count(a_load_count), .load_error(a_load_error));

  program_memory #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(24), .DEPTH(200), .INIT_FILE("")) u_b (
    .clock(clock), .reset_n(reset_n), .pc(pc), .fetch_req(fetch_req),
    .instruction(b_instruction), .instruction_valid(b_instruction_valid),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(b_load_ready), .loading(b_loading), .load_count(b_load_count), .load_error(b_load_error));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_byte  = b;
    load_valid = 1'b1;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] addr);
    pc        = addr;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_instr", 32'(a_instruction), 32'h0);
    chk("rst_valid", 32'(a_instruction_valid), 32'h0);
    chk("rst_ready", 32'(a_load_ready), 32'h0);
    chk("rst_loading", 32'(a_loading), 32'h0);
    chk("rst_count", 32'(a_load_count), 32'h0);
    chk("rst_error", 32'(a_load_error), 32'h0);
    reset_n = 1'b1;
    tick();

    // load AB CD 12 34
    start_load();
    chk("ld_loading", 32'(a_loading), 32'h1);
    chk("ld_ready", 32'(a_load_ready), 32'h1);
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    chk("ld_cnt1", 32'(a_load_count), 32'h1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    chk("ld_count_a", 32'(a_load_count), 32'h2);
    chk("ld_count_b", 32'(b_load_count), 32'h2);
    chk("ld_done", 32'(a_loading), 32'h0);
    chk("ld_err", 32'(a_load_error), 32'h0);

    // back-to-back fetch then idle
    pc = 8'd0; fetch_req = 1'b1;
    tick();
    chk("f0_a", 32'(a_instruction), 32'hABCD);
    chk("f0_b", 32'(b_instruction), 32'hABCD12);
    chk("f0_v", 32'(a_instruction_valid), 32'h1);
    pc = 8'd1;
    tick();
    chk("f1_a", 32'(a_instruction), 32'h1234);
    chk("f1_b", 32'(b_instruction), 32'h340000);
    chk("f1_v", 32'(a_instruction_valid), 32'h1);
    fetch_req = 1'b0;
    tick();
    chk("idle_v", 32'(a_instruction_valid), 32'h0);
    chk("idle_hold", 32'(a_instruction), 32'h1234);

    // partial word on the 24-bit instance
    start_load();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    chk("pw_count_b", 32'(b_load_count), 32'h2);
    fetch(8'd0);
    chk("pw0_b", 32'(b_instruction), 32'h010203);
    chk("pw0_a", 32'(a_instruction), 32'h0102);
    fetch(8'd1);
    chk("pw1_b", 32'(b_instruction), 32'h040000);
    chk("pw1_a", 32'(a_instruction), 32'h0304);

    // overrun: 10 bytes into DEPTH=4
    start_load();
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i), 1'b0);
    chk("ov_ready", 32'(a_load_ready), 32'h1);
    chk("ov_err_mid", 32'(a_load_error), 32'h1);
    send(8'h19, 1'b1);
    chk("ov_count", 32'(a_load_count), 32'h4);
    chk("ov_err", 32'(a_load_error), 32'h1);
    chk("ov_b_count", 32'(b_load_count), 32'h4);
    chk("ov_b_err", 32'(b_load_error), 32'h0);
    fetch(8'd0); chk("ov0", 32'(a_instruction), 32'h1011);
    fetch(8'd1); chk("ov1", 32'(a_instruction), 32'h1213);
    fetch(8'd2); chk("ov2", 32'(a_instruction), 32'h1415);
    fetch(8'd3); chk("ov3", 32'(a_instruction), 32'h1617);
    chk("ov3_b", 32'(b_instruction), 32'h190000);
    fetch(8'd4); chk("oor_a4", 32'(a_instruction), 32'h0);
    chk("oor_a4_v", 32'(a_instruction_valid), 32'h1);
    fetch(8'd3);

    // load_start beats fetch_req, and clears the sticky error
    pc = 8'd0; fetch_req = 1'b1; load_start = 1'b1;
    tick();
    fetch_req = 1'b0; load_start = 1'b0;
    chk("pri_valid", 32'(a_instruction_valid), 32'h0);
    chk("pri_loading", 32'(a_loading), 32'h1);
    chk("pri_err_clr", 32'(a_load_error), 32'h0);
    chk("pri_count_clr", 32'(a_load_count), 32'h0);
    chk("pri_instr_hold", 32'(a_instruction), 32'h1617);

    // async reset after 3 bytes
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    chk("rm_count", 32'(a_load_count), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_instr", 32'(a_instruction), 32'h0);
    chk("rm_loading", 32'(a_loading), 32'h0);
    chk("rm_ready", 32'(a_load_ready), 32'h0);
    chk("rm_count0", 32'(a_load_count), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    fetch(8'd0); chk("rm_mem0_a", 32'(a_instruction), 32'hAABB);
    chk("rm_mem0_b", 32'(b_instruction), 32'hAABBCC);
    fetch(8'd1); chk("rm_mem1_a", 32'(a_instruction), 32'h1213);
    chk("rm_mem1_b", 32'(b_instruction), 32'h131415);

    // out of range on DEPTH=200
    fetch(8'd250);
    chk("oor_b", 32'(b_instruction), 32'h0);
    chk("oor_b_v", 32'(b_instruction_valid), 32'h1);
    chk("oor_a", 32'(a_instruction), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
